// File: rtl/ddr_bank_timing_tracker_if.sv
`timescale 1ns/1ps
// Command/query/status bundle between the DDR scheduler (master) and the bank timing tracker (slave).
// TIMING_VIOL_LOG_EN adds the first-violation capture signals.
interface ddr_bank_timing_tracker_if #(
  parameter int NUM_BG       = 8,
  parameter int BANKS_PER_BG = 4
);
  localparam int BG_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
  localparam int BA_W = (BANKS_PER_BG > 1) ? $clog2(BANKS_PER_BG) : 1;
  localparam int NB   = NUM_BG * BANKS_PER_BG;

  logic            cmd_valid;
  logic [2:0]      cmd_type;
  logic [BG_W-1:0] cmd_bg;
  logic [BA_W-1:0] cmd_ba;
  logic [2:0]      qry_type;
  logic [BG_W-1:0] qry_bg;
  logic [BA_W-1:0] qry_ba;
  logic            qry_legal;
  logic            cmd_violation;
  logic [15:0]     viol_count;
  logic [NB-1:0]   bank_open;
  logic            ref_busy;
`ifdef TIMING_VIOL_LOG_EN
  logic [2+BG_W+BA_W:0] first_viol;
  logic                 first_viol_vld;
`endif

  modport master (
`ifdef TIMING_VIOL_LOG_EN
    input  first_viol, first_viol_vld,
`endif
    output cmd_valid, cmd_type, cmd_bg, cmd_ba, qry_type, qry_bg, qry_ba,
    input  qry_legal, cmd_violation, viol_count, bank_open, ref_busy
  );

  modport slave (
`ifdef TIMING_VIOL_LOG_EN
    output first_viol, first_viol_vld,
`endif
    input  cmd_valid, cmd_type, cmd_bg, cmd_ba, qry_type, qry_bg, qry_ba,
    output qry_legal, cmd_violation, viol_count, bank_open, ref_busy
  );
endinterface

// File: rtl/ddr_bank_timing_tracker.sv
`timescale 1ns/1ps
// Per-bank / per-bank-group DDR5 timing legality tracker: answers command-legality queries and flags illegal issues.
// Optional macro TIMING_VIOL_LOG_EN latches the first violating command (type, bg, ba) until reset.
module ddr_bank_timing_tracker #(
  parameter int NUM_BG       = 8,
  parameter int BANKS_PER_BG = 4,
  parameter int CNT_W        = 10,
  parameter int T_RC         = 230,
  parameter int T_RAS        = 152,
  parameter int T_RCD        = 78,
  parameter int T_RP         = 78,
  parameter int T_RTP        = 36,
  parameter int T_CWL        = 76,
  parameter int T_BURST      = 16,
  parameter int T_WR         = 60,
  parameter int T_RFC        = 590,
  parameter int T_RRD_L      = 24,
  parameter int T_RRD_S      = 16,
  parameter int T_CCD_L      = 24,
  parameter int T_CCD_S      = 16,
  parameter int T_CCD_L_WR   = 96,
  parameter int T_CCD_S_WR   = 16,
  parameter int T_RTW        = 32,
  parameter int T_CCD_L_WTR  = 140,
  parameter int T_CCD_S_WTR  = 104
) (
  input logic clk,
  input logic rst_n,
  ddr_bank_timing_tracker_if.slave bus
);
  localparam int BG_W    = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
  localparam int BA_W    = (BANKS_PER_BG > 1) ? $clog2(BANKS_PER_BG) : 1;
  localparam int NB      = NUM_BG * BANKS_PER_BG;
  localparam int NB_W    = BG_W + BA_W;
  localparam int CNT_LIM = 1 << CNT_W;

  if (T_RC - 1 >= CNT_LIM || T_RAS - 1 >= CNT_LIM || T_RCD - 1 >= CNT_LIM ||
      T_RP - 1 >= CNT_LIM || T_RTP - 1 >= CNT_LIM || T_CWL + T_BURST + T_WR - 1 >= CNT_LIM ||
      T_RFC - 1 >= CNT_LIM || T_RRD_L - 1 >= CNT_LIM || T_RRD_S - 1 >= CNT_LIM ||
      T_CCD_L - 1 >= CNT_LIM || T_CCD_S - 1 >= CNT_LIM || T_CCD_L_WR - 1 >= CNT_LIM ||
      T_CCD_S_WR - 1 >= CNT_LIM || T_RTW - 1 >= CNT_LIM || T_CCD_L_WTR - 1 >= CNT_LIM ||
      T_CCD_S_WTR - 1 >= CNT_LIM) begin : g_cnt_w_too_small
    $error("CNT_W too narrow for the configured timing parameters");
  end

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                         CMD_WR = 3'd3, CMD_PRE = 3'd4, CMD_REF = 3'd5;

  localparam logic [CNT_W-1:0] L_RC      = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] L_RAS     = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] L_RCD     = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] L_RP      = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_RTP     = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] L_WRP     = CNT_W'(T_CWL + T_BURST + T_WR - 1);
  localparam logic [CNT_W-1:0] L_RFC     = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] L_RRD_L   = CNT_W'(T_RRD_L - 1);
  localparam logic [CNT_W-1:0] L_RRD_S   = CNT_W'(T_RRD_S - 1);
  localparam logic [CNT_W-1:0] L_CCD_L   = CNT_W'(T_CCD_L - 1);
  localparam logic [CNT_W-1:0] L_CCD_S   = CNT_W'(T_CCD_S - 1);
  localparam logic [CNT_W-1:0] L_CCDW_L  = CNT_W'(T_CCD_L_WR - 1);
  localparam logic [CNT_W-1:0] L_CCDW_S  = CNT_W'(T_CCD_S_WR - 1);
  localparam logic [CNT_W-1:0] L_RTW     = CNT_W'(T_RTW - 1);
  localparam logic [CNT_W-1:0] L_WTR_L   = CNT_W'(T_CCD_L_WTR - 1);
  localparam logic [CNT_W-1:0] L_WTR_S   = CNT_W'(T_CCD_S_WTR - 1);

  logic [CNT_W-1:0] t_act_q [NB];
  logic [CNT_W-1:0] t_act_d [NB];
  logic [CNT_W-1:0] t_pre_q [NB];
  logic [CNT_W-1:0] t_pre_d [NB];
  logic [CNT_W-1:0] t_col_q [NB];
  logic [CNT_W-1:0] t_col_d [NB];
  logic [CNT_W-1:0] act_bg_q [NUM_BG];
  logic [CNT_W-1:0] act_bg_d [NUM_BG];
  logic [CNT_W-1:0] rd_bg_q [NUM_BG];
  logic [CNT_W-1:0] rd_bg_d [NUM_BG];
  logic [CNT_W-1:0] wr_bg_q [NUM_BG];
  logic [CNT_W-1:0] wr_bg_d [NUM_BG];
  logic [CNT_W-1:0] t_ref_q, t_ref_d;
  logic [NB-1:0]    open_q, open_d;
  logic             viol_q, viol_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cmd_ok;
  logic [NB_W-1:0]  cmd_b;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // A reload never shortens an already-pending constraint.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] t, input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] td;
    td = dec(t);
    return (td > lim) ? td : lim;
  endfunction

  function automatic logic is_legal(input logic [2:0] typ, input logic [BG_W-1:0] bg,
                                    input logic [BA_W-1:0] ba);
    logic [NB_W-1:0] b;
    logic            ok;
    b  = {bg, ba};
    ok = 1'b0;
    case (typ)
      CMD_NOP: ok = 1'b1;
      CMD_ACT: ok = !open_q[b] && t_act_q[b] == '0 && act_bg_q[bg] == '0 && t_ref_q == '0;
      CMD_RD:  ok = open_q[b] && t_col_q[b] == '0 && rd_bg_q[bg] == '0 && t_ref_q == '0;
      CMD_WR:  ok = open_q[b] && t_col_q[b] == '0 && wr_bg_q[bg] == '0 && t_ref_q == '0;
      CMD_PRE: ok = open_q[b] && t_pre_q[b] == '0 && t_ref_q == '0;
      CMD_REF: begin
        ok = (open_q == '0) && t_ref_q == '0;
        for (int i = 0; i < NB; i++) if (t_act_q[i] != '0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign cmd_b  = {bus.cmd_bg, bus.cmd_ba};
  assign cmd_ok = is_legal(bus.cmd_type, bus.cmd_bg, bus.cmd_ba);

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      t_act_d[i] = dec(t_act_q[i]);
      t_pre_d[i] = dec(t_pre_q[i]);
      t_col_d[i] = dec(t_col_q[i]);
    end
    for (int g = 0; g < NUM_BG; g++) begin
      act_bg_d[g] = dec(act_bg_q[g]);
      rd_bg_d[g]  = dec(rd_bg_q[g]);
      wr_bg_d[g]  = dec(wr_bg_q[g]);
    end
    t_ref_d = dec(t_ref_q);
    open_d  = open_q;
    viol_d  = 1'b0;
    cnt_d   = cnt_q;
    if (bus.cmd_valid && !cmd_ok) begin
      viol_d = 1'b1;
      cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else if (bus.cmd_valid) begin
      case (bus.cmd_type)
        CMD_ACT: begin
          open_d[cmd_b]  = 1'b1;
          t_col_d[cmd_b] = ld(t_col_q[cmd_b], L_RCD);
          t_pre_d[cmd_b] = ld(t_pre_q[cmd_b], L_RAS);
          t_act_d[cmd_b] = ld(t_act_q[cmd_b], L_RC);
          for (int g = 0; g < NUM_BG; g++)
            act_bg_d[g] = ld(act_bg_q[g], (g == int'(bus.cmd_bg)) ? L_RRD_L : L_RRD_S);
        end
        CMD_RD: begin
          t_pre_d[cmd_b] = ld(t_pre_q[cmd_b], L_RTP);
          for (int g = 0; g < NUM_BG; g++) begin
            rd_bg_d[g] = ld(rd_bg_q[g], (g == int'(bus.cmd_bg)) ? L_CCD_L : L_CCD_S);
            wr_bg_d[g] = ld(wr_bg_q[g], L_RTW);
          end
        end
        CMD_WR: begin
          t_pre_d[cmd_b] = ld(t_pre_q[cmd_b], L_WRP);
          for (int g = 0; g < NUM_BG; g++) begin
            wr_bg_d[g] = ld(wr_bg_q[g], (g == int'(bus.cmd_bg)) ? L_CCDW_L : L_CCDW_S);
            rd_bg_d[g] = ld(rd_bg_q[g], (g == int'(bus.cmd_bg)) ? L_WTR_L : L_WTR_S);
          end
        end
        CMD_PRE: begin
          open_d[cmd_b]  = 1'b0;
          t_act_d[cmd_b] = ld(t_act_q[cmd_b], L_RP);
        end
        CMD_REF: t_ref_d = ld(t_ref_q, L_RFC);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        t_act_q[i] <= '0;
        t_pre_q[i] <= '0;
        t_col_q[i] <= '0;
      end
      for (int g = 0; g < NUM_BG; g++) begin
        act_bg_q[g] <= '0;
        rd_bg_q[g]  <= '0;
        wr_bg_q[g]  <= '0;
      end
      t_ref_q <= '0;
      open_q  <= '0;
      viol_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      t_act_q  <= t_act_d;
      t_pre_q  <= t_pre_d;
      t_col_q  <= t_col_d;
      act_bg_q <= act_bg_d;
      rd_bg_q  <= rd_bg_d;
      wr_bg_q  <= wr_bg_d;
      t_ref_q  <= t_ref_d;
      open_q   <= open_d;
      viol_q   <= viol_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.qry_legal     = is_legal(bus.qry_type, bus.qry_bg, bus.qry_ba);
  assign bus.cmd_violation = viol_q;
  assign bus.viol_count    = cnt_q;
  assign bus.bank_open     = open_q;
  assign bus.ref_busy      = (t_ref_q != '0);

`ifdef TIMING_VIOL_LOG_EN
  logic [2+NB_W:0] fv_q, fv_d;
  logic            fv_vld_q, fv_vld_d;

  always_comb begin
    fv_d     = fv_q;
    fv_vld_d = fv_vld_q;
    if (bus.cmd_valid && !cmd_ok && !fv_vld_q) begin
      fv_d     = {bus.cmd_type, bus.cmd_bg, bus.cmd_ba};
      fv_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q     <= '0;
      fv_vld_q <= 1'b0;
    end else begin
      fv_q     <= fv_d;
      fv_vld_q <= fv_vld_d;
    end
  end

  assign bus.first_viol     = fv_q;
  assign bus.first_viol_vld = fv_vld_q;
`endif
endmodule

// File: tb/tb_ddr_bank_timing_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for ddr_bank_timing_tracker: directed timing scenarios plus random traffic
// checked against an earliest-legal-cycle reference model.
module tb_ddr_bank_timing_tracker;
  localparam int NUM_BG = 8, BANKS_PER_BG = 4, NB = 32, BG_W = 3, BA_W = 2;
  localparam int T_RC = 230, T_RAS = 152, T_RCD = 78, T_RP = 78, T_RTP = 36;
  localparam int T_WRP = 76 + 16 + 60, T_RFC = 590, T_RRD_L = 24, T_RRD_S = 16;
  localparam int T_CCD_L = 24, T_CCD_S = 16, T_CCD_L_WR = 96, T_CCD_S_WR = 16;
  localparam int T_RTW = 32, T_CCD_L_WTR = 140, T_CCD_S_WTR = 104;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddr_bank_timing_tracker_if #(.NUM_BG(NUM_BG), .BANKS_PER_BG(BANKS_PER_BG)) bus ();
  ddr_bank_timing_tracker #(.NUM_BG(NUM_BG), .BANKS_PER_BG(BANKS_PER_BG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int asserts = 0, fails = 0;
  // Reference model: earliest edge index at which each constraint is satisfied.
  int nedge = 0;
  int r_act[NB], r_pre[NB], r_col[NB];
  int r_actg[NUM_BG], r_rd[NUM_BG], r_wr[NUM_BG];
  int r_ref;
  bit m_open[NB];
  int m_cnt;
  bit m_viol;

  function automatic int later(int r, int n);
    return (r > nedge + n) ? r : nedge + n;
  endfunction

  function automatic bit m_legal(int typ, int bg, int ba);
    int b;
    b = bg * BANKS_PER_BG + ba;
    case (typ)
      0: return 1'b1;
      1: return !m_open[b] && nedge >= r_act[b] && nedge >= r_actg[bg] && nedge >= r_ref;
      2: return m_open[b] && nedge >= r_col[b] && nedge >= r_rd[bg] && nedge >= r_ref;
      3: return m_open[b] && nedge >= r_col[b] && nedge >= r_wr[bg] && nedge >= r_ref;
      4: return m_open[b] && nedge >= r_pre[b] && nedge >= r_ref;
      5: begin
        for (int i = 0; i < NB; i++) if (m_open[i] || nedge < r_act[i]) return 1'b0;
        return nedge >= r_ref;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] m_open_vec();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_open[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NB; i++) begin r_act[i] = 0; r_pre[i] = 0; r_col[i] = 0; m_open[i] = 0; end
    for (int g = 0; g < NUM_BG; g++) begin r_actg[g] = 0; r_rd[g] = 0; r_wr[g] = 0; end
    r_ref = 0; m_cnt = 0; m_viol = 0;
  endtask

  // Drive one command for one clock edge and advance the model accordingly.
  task automatic issue(input bit v, input int typ, input int bg, input int ba);
    bit ok;
    int b;
    bus.cmd_valid = v; bus.cmd_type = 3'(typ); bus.cmd_bg = BG_W'(bg); bus.cmd_ba = BA_W'(ba);
    ok = !v || m_legal(typ, bg, ba);
    b  = bg * BANKS_PER_BG + ba;
    @(posedge clk);
    m_viol = !ok;
    if (!ok) begin
      if (m_cnt < 65535) m_cnt++;
    end else if (v) begin
      case (typ)
        1: begin
          m_open[b] = 1; r_col[b] = later(r_col[b], T_RCD);
          r_pre[b] = later(r_pre[b], T_RAS); r_act[b] = later(r_act[b], T_RC);
          for (int g = 0; g < NUM_BG; g++) r_actg[g] = later(r_actg[g], (g == bg) ? T_RRD_L : T_RRD_S);
        end
        2: begin
          r_pre[b] = later(r_pre[b], T_RTP);
          for (int g = 0; g < NUM_BG; g++) begin
            r_rd[g] = later(r_rd[g], (g == bg) ? T_CCD_L : T_CCD_S);
            r_wr[g] = later(r_wr[g], T_RTW);
          end
        end
        3: begin
          r_pre[b] = later(r_pre[b], T_WRP);
          for (int g = 0; g < NUM_BG; g++) begin
            r_wr[g] = later(r_wr[g], (g == bg) ? T_CCD_L_WR : T_CCD_S_WR);
            r_rd[g] = later(r_rd[g], (g == bg) ? T_CCD_L_WTR : T_CCD_S_WTR);
          end
        end
        4: begin m_open[b] = 0; r_act[b] = later(r_act[b], T_RP); end
        5: r_ref = later(r_ref, T_RFC);
        default: ;
      endcase
    end
    nedge++;
    #1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 3'd0;
  endtask

  task automatic set_qry(input int typ, input int bg, input int ba);
    bus.qry_type = 3'(typ); bus.qry_bg = BG_W'(bg); bus.qry_ba = BA_W'(ba);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); nedge++; end
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_type = 0; bus.cmd_bg = 0; bus.cmd_ba = 0;
    bus.qry_type = 0; bus.qry_bg = 0; bus.qry_ba = 0;
    rst_n = 1'b0;
    m_reset();
    #2;
    asserts++; if (bus.cmd_violation !== 1'b0) begin fails++; $display("FAIL reset_viol: got %0b want 0", bus.cmd_violation); end
    asserts++; if (bus.viol_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.viol_count); end
    asserts++; if (bus.bank_open !== '0) begin fails++; $display("FAIL reset_open: got %h want 0", bus.bank_open); end
    asserts++; if (bus.ref_busy !== 1'b0) begin fails++; $display("FAIL reset_ref_busy: got %0b want 0", bus.ref_busy); end
    do_reset();
    set_qry(1, 3, 2);
    asserts++; if (bus.qry_legal !== 1'b1) begin fails++; $display("FAIL reset_act_legal: got %0b want 1", bus.qry_legal); end
    set_qry(2, 3, 2);
    asserts++; if (bus.qry_legal !== 1'b0) begin fails++; $display("FAIL reset_rd_closed: got %0b want 0", bus.qry_legal); end
  endtask

  task automatic test_act_rd_pre();
    bit e;
    do_reset();
    issue(1, 1, 0, 0);
    asserts++; if (bus.cmd_violation !== 1'b0) begin fails++; $display("FAIL act_issue: viol %0b want 0", bus.cmd_violation); end
    asserts++; if (bus.bank_open[0] !== 1'b1) begin fails++; $display("FAIL act_open: got %0b want 1", bus.bank_open[0]); end
    for (int k = 1; k <= 160; k++) begin
      set_qry(2, 0, 0);
      e = m_legal(2, 0, 0);
      asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL rd_after_act k=%0d: got %0b want %0b", k, bus.qry_legal, e); end
      if (k == 77 || k == 78) begin
        asserts++; if (bus.qry_legal !== (k >= 78)) begin fails++; $display("FAIL trcd_edge k=%0d: got %0b want %0b", k, bus.qry_legal, k >= 78); end
      end
      set_qry(4, 0, 0);
      e = m_legal(4, 0, 0);
      asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL pre_after_act k=%0d: got %0b want %0b", k, bus.qry_legal, e); end
      if (k == 151 || k == 152) begin
        asserts++; if (bus.qry_legal !== (k >= 152)) begin fails++; $display("FAIL tras_edge k=%0d: got %0b want %0b", k, bus.qry_legal, k >= 152); end
      end
      issue(0, 0, 0, 0);
    end
    issue(1, 4, 0, 0);
    asserts++; if (bus.cmd_violation !== 1'b0 || bus.bank_open[0] !== 1'b0) begin
      fails++; $display("FAIL pre_close: viol %0b open %0b want 0 0", bus.cmd_violation, bus.bank_open[0]);
    end
  endtask

  task automatic test_rrd();
    bit e;
    do_reset();
    issue(1, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      set_qry(1, 0, 1);
      e = m_legal(1, 0, 1);
      asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL rrd_l k=%0d: got %0b want %0b", k, bus.qry_legal, e); end
      if (k == 23 || k == 24) begin
        asserts++; if (bus.qry_legal !== (k >= 24)) begin fails++; $display("FAIL rrd_l_edge k=%0d: got %0b want %0b", k, bus.qry_legal, k >= 24); end
      end
      set_qry(1, 1, 0);
      e = m_legal(1, 1, 0);
      asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL rrd_s k=%0d: got %0b want %0b", k, bus.qry_legal, e); end
      if (k == 15 || k == 16) begin
        asserts++; if (bus.qry_legal !== (k >= 16)) begin fails++; $display("FAIL rrd_s_edge k=%0d: got %0b want %0b", k, bus.qry_legal, k >= 16); end
      end
      issue(k == 10, (k == 10) ? 1 : 0, 0, 1);
      asserts++; if (bus.cmd_violation !== (k == 10)) begin fails++; $display("FAIL rrd_viol_pulse k=%0d: got %0b want %0b", k, bus.cmd_violation, k == 10); end
      if (k == 10) begin
        asserts++; if (bus.viol_count !== 16'd1) begin fails++; $display("FAIL rrd_viol_count: got %0d want 1", bus.viol_count); end
        asserts++; if (bus.bank_open[1] !== 1'b0) begin fails++; $display("FAIL rrd_no_open: got %0b want 0", bus.bank_open[1]); end
      end
    end
  endtask

  task automatic test_wr_turnaround();
    int qt[4] = '{2, 2, 3, 3};
    int qg[4] = '{2, 3, 2, 3};
    int lim[4] = '{140, 104, 96, 16};
    bit e;
    do_reset();
    issue(1, 1, 2, 0);
    repeat (16) issue(0, 0, 0, 0);
    issue(1, 1, 3, 0);
    repeat (100) issue(0, 0, 0, 0);
    issue(1, 3, 2, 0);
    asserts++; if (bus.cmd_violation !== 1'b0) begin fails++; $display("FAIL wr_issue: viol %0b want 0", bus.cmd_violation); end
    for (int k = 1; k <= 150; k++) begin
      for (int j = 0; j < 4; j++) begin
        set_qry(qt[j], qg[j], 0);
        e = m_legal(qt[j], qg[j], 0);
        asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL wr_turn q%0d k=%0d: got %0b want %0b", j, k, bus.qry_legal, e); end
        if (k == lim[j] - 1 || k == lim[j]) begin
          asserts++; if (bus.qry_legal !== (k >= lim[j])) begin fails++; $display("FAIL wr_turn_edge q%0d k=%0d: got %0b want %0b", j, k, bus.qry_legal, k >= lim[j]); end
        end
      end
      issue(0, 0, 0, 0);
    end
  endtask

  task automatic test_refresh();
    bit e;
    int n;
    do_reset();
    issue(1, 1, 1, 1);
    repeat (5) issue(0, 0, 0, 0);
    issue(1, 5, 0, 0);
    asserts++; if (bus.cmd_violation !== 1'b1 || bus.ref_busy !== 1'b0) begin
      fails++; $display("FAIL ref_open_bank: viol %0b busy %0b want 1 0", bus.cmd_violation, bus.ref_busy);
    end
    n = 0;
    while (!m_legal(4, 1, 1) && n < 400) begin issue(0, 0, 0, 0); n++; end
    issue(1, 4, 1, 1);
    asserts++; if (bus.cmd_violation !== 1'b0) begin fails++; $display("FAIL ref_pre: viol %0b want 0", bus.cmd_violation); end
    n = 0;
    while (!m_legal(5, 0, 0) && n < 400) begin
      set_qry(5, 0, 0);
      asserts++; if (bus.qry_legal !== 1'b0) begin fails++; $display("FAIL ref_wait_qry n=%0d: got %0b want 0", n, bus.qry_legal); end
      issue(0, 0, 0, 0); n++;
    end
    set_qry(5, 0, 0);
    asserts++; if (bus.qry_legal !== 1'b1) begin fails++; $display("FAIL ref_ready_qry: got %0b want 1", bus.qry_legal); end
    issue(1, 5, 0, 0);
    asserts++; if (bus.cmd_violation !== 1'b0) begin fails++; $display("FAIL ref_issue: viol %0b want 0", bus.cmd_violation); end
    for (int k = 1; k <= 595; k++) begin
      asserts++; if (bus.ref_busy !== (k < 590)) begin fails++; $display("FAIL ref_busy k=%0d: got %0b want %0b", k, bus.ref_busy, k < 590); end
      set_qry(1, 0, 0);
      e = m_legal(1, 0, 0);
      asserts++; if (bus.qry_legal !== e || bus.qry_legal !== (k >= 590)) begin
        fails++; $display("FAIL ref_act_block k=%0d: got %0b want %0b", k, bus.qry_legal, e);
      end
      issue(0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    int typ, bg, ba;
    bit v, e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_qry($urandom % 8, $urandom % NUM_BG, $urandom % BANKS_PER_BG);
      e = m_legal(int'(bus.qry_type), int'(bus.qry_bg), int'(bus.qry_ba));
      asserts++; if (bus.qry_legal !== e) begin fails++; $display("FAIL rand_qry n=%0d: got %0b want %0b", n, bus.qry_legal, e); end
      v   = ($urandom % 4) != 0;
      typ = (($urandom % 16) == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
      bg  = (($urandom % 2) == 0) ? int'($urandom % 2) : int'($urandom % NUM_BG);
      ba  = (($urandom % 2) == 0) ? 0 : int'($urandom % BANKS_PER_BG);
      issue(v, typ, bg, ba);
      asserts++; if (bus.cmd_violation !== m_viol || bus.viol_count !== 16'(m_cnt)) begin
        fails++; $display("FAIL rand_cmd n=%0d: viol %0b cnt %0d want %0b %0d", n, bus.cmd_violation, bus.viol_count, m_viol, m_cnt);
      end
      asserts++; if (bus.bank_open !== m_open_vec() || bus.ref_busy !== (r_ref > nedge)) begin
        fails++; $display("FAIL rand_state n=%0d: open %h busy %0b want %h %0b", n, bus.bank_open, bus.ref_busy, m_open_vec(), r_ref > nedge);
      end
    end
  endtask

  task automatic test_saturation_and_async_reset();
    do_reset();
    issue(1, 1, 0, 0);
    for (int i = 1; i <= 65540; i++) begin
      issue(1, 4, 1, 0);
      if (i == 1 || i == 65534 || i == 65535 || i == 65540) begin
        asserts++; if (bus.viol_count !== 16'((i < 65535) ? i : 65535) || bus.viol_count !== 16'(m_cnt)) begin
          fails++; $display("FAIL sat_count i=%0d: got %0d want %0d", i, bus.viol_count, (i < 65535) ? i : 65535);
        end
      end
    end
    asserts++; if (bus.cmd_violation !== 1'b1 || bus.bank_open[0] !== 1'b1) begin
      fails++; $display("FAIL sat_state: viol %0b open %0b want 1 1", bus.cmd_violation, bus.bank_open[0]);
    end
    rst_n = 1'b0;
    #1;
    asserts++; if (bus.cmd_violation !== 1'b0 || bus.viol_count !== 16'd0 || bus.bank_open !== '0 || bus.ref_busy !== 1'b0) begin
      fails++; $display("FAIL async_reset: viol %0b cnt %0d open %h busy %0b want all 0", bus.cmd_violation, bus.viol_count, bus.bank_open, bus.ref_busy);
    end
    rst_n = 1'b1;
    m_reset();
    set_qry(1, 0, 0);
    asserts++; if (bus.qry_legal !== 1'b1) begin fails++; $display("FAIL post_reset_qry: got %0b want 1", bus.qry_legal); end
    issue(1, 1, 0, 0);
    asserts++; if (bus.cmd_violation !== 1'b0 || bus.bank_open[0] !== 1'b1) begin
      fails++; $display("FAIL post_reset_act: viol %0b open %0b want 0 1", bus.cmd_violation, bus.bank_open[0]);
    end
  endtask

  initial begin
    test_reset();
    test_act_rd_pre();
    test_rrd();
    test_wr_turnaround();
    test_refresh();
    test_random();
    test_saturation_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/ddr_bank_timing_tracker.md
Name: ddr_bank_timing_tracker
Overview:
Parametrised per-bank / per-bank-group DDR5 timing legality tracker for the memory-controller scheduler; the next generation of the flat timing-constant package. It holds open/closed state and countdown timers for NUM_BG×BANKS_PER_BG banks, answers "is command X legal now" queries, and flags illegal issued commands. All timings are in scheduler clock ticks (2 ticks/ns).
Parameters:
NUM_BG, 8, bank groups (power of 2)
BANKS_PER_BG, 4, banks per group (power of 2)
CNT_W, 10, timer width; every T_* minus 1 must fit (elaboration error otherwise)
T_RC, 230, ACT→ACT same bank
T_RAS, 152, ACT→PRE same bank
T_RCD, 78, ACT→RD/WR same bank
T_RP, 78, PRE→ACT same bank
T_RTP, 36, RD→PRE same bank
T_CWL / T_BURST / T_WR, 76 / 16 / 60, WR→PRE same bank = sum (152)
T_RFC, 590, REF→any command
T_RRD_L / T_RRD_S, 24 / 16, ACT→ACT same / other bank group
T_CCD_L / T_CCD_S, 24 / 16, RD→RD same / other group
T_CCD_L_WR / T_CCD_S_WR, 96 / 16, WR→WR same / other group
T_RTW, 32, RD→WR any group
T_CCD_L_WTR / T_CCD_S_WTR, 140 / 104, WR→RD same / other group
Ports:
clk  in  1  scheduler clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command issued this cycle
cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6-7 treated as illegal
cmd_bg / cmd_ba  in  log2(NUM_BG) / log2(BANKS_PER_BG)  target bank
qry_type, qry_bg, qry_ba  in  same widths  query command
qry_legal  out  1  combinational: query legal against current registered state
cmd_violation  out  1  registered one-cycle pulse: issued command was illegal
viol_count  out  16  saturating violation count
bank_open  out  NUM_BG*BANKS_PER_BG  open bitmap, index bg*BANKS_PER_BG+ba
ref_busy  out  1  refresh timer non-zero
Behaviour:
- Reset (async, rst_n=0): all timers 0, all banks closed, cmd_violation=0, viol_count=0, ref_busy=0.
- Timers count down by 1 per cycle, saturate at 0; "ready" = timer==0. Loading uses max(current, N-1): a command at edge c permits dependent command from edge c+N.
- Per-bank timers: t_act, t_pre, t_col. Per-group timers: act_bg, rd_bg, wr_bg. Global: t_ref.
- ACT legal: bank closed, t_act, act_bg[bg], t_ref ready. Effect: open; t_rcd←T_RCD-1 into t_col; t_pre←T_RAS-1; t_act←T_RC-1; act_bg[bg]←T_RRD_L-1, other groups ←T_RRD_S-1.
- RD legal: bank open, t_col, rd_bg[bg], t_ref ready. Effect: t_pre←T_RTP-1; rd_bg[bg]←T_CCD_L-1, others T_CCD_S-1; all wr_bg←T_RTW-1.
- WR legal: bank open, t_col, wr_bg[bg], t_ref ready. Effect: t_pre←T_CWL+T_BURST+T_WR-1; wr_bg[bg]←T_CCD_L_WR-1, others T_CCD_S_WR-1; rd_bg[bg]←T_CCD_L_WTR-1, others T_CCD_S_WTR-1.
- PRE legal: bank open, t_pre, t_ref ready. Effect: closed; t_act←T_RP-1. PRE to closed bank is illegal.
- REF legal: all banks closed, all t_act ready, t_ref ready. Effect: t_ref←T_RFC-1.
- NOP/cmd_valid=0: always legal, no effect.
- Illegal issued command: no state update; cmd_violation=1 next cycle; viol_count+1, holds at 65535.
- Query evaluates pre-edge state; a command issued the same cycle does not affect qry_legal until next cycle.
Optional Feature:
TIMING_VIOL_LOG_EN: adds output first_viol (3+BG_W+BA_W bits: type, bg, ba) and first_viol_vld, latched on first violation after reset, held until reset. Without macro: ports and logic absent.
Test Plan:
- ACT bg0/ba0 at cycle 0 → RD same bank qry_legal=0 cycles 1-77, =1 at 78; PRE illegal until 152.
- ACT bg0/ba0 at 0 → ACT bg0/ba1 legal at 24, ACT bg1/ba0 legal at 16; issuing bg0/ba1 at 10 → cmd_violation at 11, viol_count=1, bank_open bit1 stays 0.
- WR bg2/ba0 at cycle t → RD bg2 legal at t+140, RD bg3 legal at t+104, WR bg2 at t+96, WR bg3 at t+16.
- REF with one bank open → violation; all closed → ref_busy=1 for 590 cycles, ACT illegal until cycle 590.
- 65536+ violations → viol_count saturates 65535; rst_n low mid-sequence → all outputs 0 immediately, ACT legal next cycle.
